// File: rtl/vpu_dcache_responder_if.sv
// VPU word-request port plus held-request/ack memory port of the D$ responder.
// Signal suffixes are from the responder's point of view; slave = responder, master = LSU/memory side.
interface vpu_dcache_responder_if #(
   parameter int ADDR_W = 32
);
   logic              dcache_vpu_request_i;
   logic [3:0]        dcache_vpu_write_i;
   logic [ADDR_W-1:0] dcache_vpu_addr_i;
   logic [31:0]       dcache_vpu_in_i;
   logic              dcache_vpu_wait_o;
   logic [31:0]       dcache_vpu_out_o;
   logic              mem_req_o;
   logic [3:0]        mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_ack_i;
   logic [31:0]       mem_rdata_i;

   modport slave (
      input  dcache_vpu_request_i, dcache_vpu_write_i, dcache_vpu_addr_i, dcache_vpu_in_i,
      input  mem_ack_i, mem_rdata_i,
      output dcache_vpu_wait_o, dcache_vpu_out_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output dcache_vpu_request_i, dcache_vpu_write_i, dcache_vpu_addr_i, dcache_vpu_in_i,
      output mem_ack_i, mem_rdata_i,
      input  dcache_vpu_wait_o, dcache_vpu_out_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/vpu_dcache_responder.sv
// D$ responder for the VPU word port: serialises reads/byte-masked stores onto a held-request/ack port.
// Optional one-entry posted write buffer when VPU_DCACHE_RESP_WRBUF_EN is defined.
//   state    | meaning
//   READY    | idle, wait_o=0, a request is accepted
//   MEM_WAIT | latched request outstanding on memory port, wait_o=1
module vpu_dcache_responder #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   vpu_dcache_responder_if.slave bus,
   output logic                  protocol_err_o
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic {READY = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [BE_W-1:0]   r_be;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_out;
   logic              r_err;
   logic              w_accept;
   logic              w_latch;
   logic              w_done;
   logic [ADDR_W-1:0] w_word_addr;

   assign w_word_addr = bus.dcache_vpu_addr_i & ~ADDR_W'(3);
   assign w_accept    = (r_state == READY) && bus.dcache_vpu_request_i;

`ifdef VPU_DCACHE_RESP_WRBUF_EN
   logic              r_wb_valid;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [BE_W-1:0]   r_wb_be;
   logic [DATA_W-1:0] r_wb_data;
   logic              w_post;

   // The buffer always owns the memory port first, so the latched request waits behind it.
   assign w_post  = w_accept && (bus.dcache_vpu_write_i != '0) && !r_wb_valid;
   assign w_latch = w_accept && !w_post;
   assign w_done  = (r_state == MEM_WAIT) && bus.mem_ack_i && !r_wb_valid;

   assign bus.mem_req_o   = r_wb_valid || (r_state == MEM_WAIT);
   assign bus.mem_we_o    = r_wb_valid ? r_wb_be   : r_be;
   assign bus.mem_addr_o  = r_wb_valid ? r_wb_addr : r_addr;
   assign bus.mem_wdata_o = r_wb_valid ? r_wb_data : r_wdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_be    <= '0;
         r_wb_data  <= '0;
      end else if (w_post) begin
         r_wb_valid <= 1'b1;
         r_wb_addr  <= w_word_addr;
         r_wb_be    <= bus.dcache_vpu_write_i;
         r_wb_data  <= bus.dcache_vpu_in_i;
      end else if (r_wb_valid && bus.mem_ack_i) begin
         r_wb_valid <= 1'b0;
      end
   end
`else
   assign w_latch = w_accept;
   assign w_done  = (r_state == MEM_WAIT) && bus.mem_ack_i;

   assign bus.mem_req_o   = (r_state == MEM_WAIT);
   assign bus.mem_we_o    = r_be;
   assign bus.mem_addr_o  = r_addr;
   assign bus.mem_wdata_o = r_wdata;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= READY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         READY:    if (w_latch) w_state_nxt = MEM_WAIT;
         MEM_WAIT: if (w_done)  w_state_nxt = READY;
         default:  w_state_nxt = READY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_out   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_latch) begin
            r_addr  <= w_word_addr;
            r_be    <= bus.dcache_vpu_write_i;
            r_wdata <= bus.dcache_vpu_in_i;
         end
         if (w_done && (r_be == '0)) begin
            r_out <= bus.mem_rdata_i;
         end
         // Requests during wait are dropped, not queued; the flag records the violation.
         if (bus.dcache_vpu_request_i && (r_state == MEM_WAIT)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.dcache_vpu_wait_o = (r_state == MEM_WAIT);
   assign bus.dcache_vpu_out_o  = r_out;
   assign protocol_err_o        = r_err;
endmodule

// File: tb/tb_vpu_dcache_responder.sv
// Scoreboard bench for vpu_dcache_responder: directed cases plus randomized traffic against a word-array model.
module tb_vpu_dcache_responder;
   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } txn_t;

`ifdef VPU_DCACHE_RESP_WRBUF_EN
   localparam logic WAIT_ST = 1'b0;
`else
   localparam logic WAIT_ST = 1'b1;
`endif

   logic clk;
   logic rst;
   logic perr;
   int   checks;
   int   failures;
   int   fixed_delay;
   int   cnt;
   bit   busy;
   bit   rd_chk;

   txn_t        exp_mem_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] phys_mem[logic [31:0]];

   vpu_dcache_responder_if #(.ADDR_W(32)) bus();

   vpu_dcache_responder #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .bus            (bus),
      .protocol_err_o (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] w);
      return phys_mem.exists(w) ? phys_mem[w] : init_word(w);
   endfunction

   // Reference: every accepted request hits memory in issue order, so a read sees all earlier stores.
   task automatic push_req(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      t.addr = w;
      t.be   = be;
      t.data = d;
      exp_mem_q.push_back(t);
      if (be == 4'h0) exp_rd_q.push_back(ref_rd(w));
      else            ref_mem[w] = merge(ref_rd(w), be, d);
   endtask

   task automatic set_mem(input logic [31:0] w, input logic [31:0] d);
      ref_mem[w]  = d;
      phys_mem[w] = d;
   endtask

   task automatic issue(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      bus.dcache_vpu_request_i = 1'b1;
      bus.dcache_vpu_write_i   = be;
      bus.dcache_vpu_addr_i    = a;
      bus.dcache_vpu_in_i      = d;
      push_req(be, a, d);
      @(negedge clk);
      bus.dcache_vpu_request_i = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((bus.dcache_vpu_wait_o || bus.mem_req_o) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) chk("idle_timeout", 32'(n), 32'(limit - 1));
   endtask

   // Memory responder and monitor: compares each completing memory transaction with the scoreboard.
   always @(negedge clk) begin
      txn_t t;
      if (rd_chk) begin
         rd_chk = 1'b0;
         if (exp_rd_q.size() == 0) chk("rd_unexpected", bus.dcache_vpu_out_o, 32'hxxxx_xxxx);
         else                      chk("rd_data", bus.dcache_vpu_out_o, exp_rd_q.pop_front());
      end
      if (bus.mem_ack_i) begin
         bus.mem_ack_i = 1'b0;
         busy = 1'b0;
      end
      if (rst || !bus.mem_req_o) begin
         busy = 1'b0;
      end else begin
         if (!busy) begin
            busy = 1'b1;
            cnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
         end
         if (cnt == 0) begin
            if (exp_mem_q.size() == 0) begin
               chk("mem_unexpected", bus.mem_addr_o, 32'hxxxx_xxxx);
            end else begin
               t = exp_mem_q.pop_front();
               chk("mem_addr", bus.mem_addr_o, t.addr);
               chk("mem_we", 32'(bus.mem_we_o), 32'(t.be));
               if (t.be != 4'h0) chk("mem_wdata", bus.mem_wdata_o, t.data);
            end
            if (bus.mem_we_o == 4'h0) begin
               bus.mem_rdata_i = phys_rd(bus.mem_addr_o);
               rd_chk = 1'b1;
            end else begin
               bus.mem_rdata_i = $urandom;
               phys_mem[bus.mem_addr_o] = merge(phys_rd(bus.mem_addr_o), bus.mem_we_o, bus.mem_wdata_o);
            end
            bus.mem_ack_i = 1'b1;
         end else begin
            cnt--;
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      int          sent;
      checks = 0; failures = 0; fixed_delay = 0; cnt = 0; busy = 1'b0; rd_chk = 1'b0;
      rst = 1'b1;
      bus.dcache_vpu_request_i = 1'b0;
      bus.dcache_vpu_write_i   = 4'h0;
      bus.dcache_vpu_addr_i    = 32'h0;
      bus.dcache_vpu_in_i      = 32'h0;
      bus.mem_ack_i            = 1'b0;
      bus.mem_rdata_i          = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_wait", 32'(bus.dcache_vpu_wait_o), 32'h0);
      chk("rst_out", bus.dcache_vpu_out_o, 32'h0);
      chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
      chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
      chk("rst_perr", 32'(perr), 32'h0);

      // Read with ack at N+1
      set_mem(32'h1000, 32'hDEADBEEF);
      fixed_delay = 0;
      issue(4'h0, 32'h1000, 32'h1234_5678);
      chk("rd_req_n1", 32'(bus.mem_req_o), 32'h1);
      chk("rd_addr_n1", bus.mem_addr_o, 32'h1000);
      chk("rd_wait_n1", 32'(bus.dcache_vpu_wait_o), 32'h1);
      @(negedge clk);
      chk("rd_wait_n2", 32'(bus.dcache_vpu_wait_o), 32'h0);
      chk("rd_out_n2", bus.dcache_vpu_out_o, 32'hDEADBEEF);

      // Unaligned store, ack delayed 3 cycles
      fixed_delay = 3;
      issue(4'b1100, 32'h2002, 32'hAABB0000);
      for (int i = 0; i < 4; i++) begin
         chk("st_req", 32'(bus.mem_req_o), 32'h1);
         chk("st_addr", bus.mem_addr_o, 32'h2000);
         chk("st_we", 32'(bus.mem_we_o), 32'hC);
         chk("st_wdata", bus.mem_wdata_o, 32'hAABB0000);
         chk("st_wait", 32'(bus.dcache_vpu_wait_o), 32'(WAIT_ST));
         chk("st_out", bus.dcache_vpu_out_o, 32'hDEADBEEF);
         @(negedge clk);
      end
      chk("st_done_req", 32'(bus.mem_req_o), 32'h0);
      chk("st_done_wait", 32'(bus.dcache_vpu_wait_o), 32'h0);
      chk("st_done_out", bus.dcache_vpu_out_o, 32'hDEADBEEF);

      // Back-to-back reads, second issued the cycle wait_o falls
      fixed_delay = 0;
      set_mem(32'h3000, 32'h3000_AAAA);
      set_mem(32'h3004, 32'h3004_BBBB);
      issue(4'h0, 32'h3000, 32'h0);
      @(negedge clk);
      chk("b2b_wait_fall", 32'(bus.dcache_vpu_wait_o), 32'h0);
      chk("b2b_out1", bus.dcache_vpu_out_o, 32'h3000_AAAA);
      issue(4'h0, 32'h3004, 32'h0);
      chk("b2b_req2", 32'(bus.mem_req_o), 32'h1);
      chk("b2b_addr2", bus.mem_addr_o, 32'h3004);
      @(negedge clk);
      chk("b2b_out2", bus.dcache_vpu_out_o, 32'h3004_BBBB);

      // Request while busy is dropped and flagged
      fixed_delay = 3;
      issue(4'h0, 32'h1000, 32'h0);
      bus.dcache_vpu_request_i = 1'b1;
      bus.dcache_vpu_write_i   = 4'hF;
      bus.dcache_vpu_addr_i    = 32'h5000;
      bus.dcache_vpu_in_i      = 32'h5555_5555;
      @(negedge clk);
      bus.dcache_vpu_request_i = 1'b0;
      chk("perr_set", 32'(perr), 32'h1);
      chk("perr_addr_held", bus.mem_addr_o, 32'h1000);
      wait_idle(50);
      @(negedge clk);
      chk("perr_sticky", 32'(perr), 32'h1);
      chk("perr_out", bus.dcache_vpu_out_o, 32'hDEADBEEF);

      // Reset while a read is outstanding
      fixed_delay = 3;
      issue(4'h0, 32'h3000, 32'h0);
      chk("rstmid_req_before", 32'(bus.mem_req_o), 32'h1);
      rst = 1'b1;
      exp_mem_q.delete();
      exp_rd_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_req", 32'(bus.mem_req_o), 32'h0);
      chk("rstmid_wait", 32'(bus.dcache_vpu_wait_o), 32'h0);
      chk("rstmid_out", bus.dcache_vpu_out_o, 32'h0);
      chk("rstmid_perr", 32'(perr), 32'h0);
      chk("rstmid_addr", bus.mem_addr_o, 32'h0);
      fixed_delay = 0;
      issue(4'h0, 32'h3004, 32'h0);
      @(negedge clk);
      chk("rstmid_fresh_out", bus.dcache_vpu_out_o, 32'h3004_BBBB);

      // Store then read of the same word
      fixed_delay = 0;
      issue(4'hF, 32'h4000, 32'h11223344);
      chk("wb_st_wait", 32'(bus.dcache_vpu_wait_o), 32'(WAIT_ST));
`ifndef VPU_DCACHE_RESP_WRBUF_EN
      wait_idle(50);
`endif
      issue(4'h0, 32'h4000, 32'hFFFF_FFFF);
      chk("wb_rd_wait", 32'(bus.dcache_vpu_wait_o), 32'h1);
      @(negedge clk);
      chk("wb_rd_done", 32'(bus.dcache_vpu_wait_o), 32'h0);
      chk("wb_rd_out", bus.dcache_vpu_out_o, 32'h11223344);

      // Randomized traffic over a small address window
      fixed_delay = -1;
      sent = 0;
      for (int cyc = 0; cyc < 20000 && sent < 300; cyc++) begin
         a  = 32'h4000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
         be = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         d  = $urandom;
         bus.dcache_vpu_write_i = be;
         bus.dcache_vpu_addr_i  = a;
         bus.dcache_vpu_in_i    = d;
         if (!bus.dcache_vpu_wait_o && $urandom_range(0, 3) != 0) begin
            bus.dcache_vpu_request_i = 1'b1;
            push_req(be, a, d);
            sent++;
         end else begin
            bus.dcache_vpu_request_i = 1'b0;
         end
         @(negedge clk);
      end
      bus.dcache_vpu_request_i = 1'b0;
      chk("rand_sent", 32'(sent), 32'd300);
      wait_idle(200);
      repeat (2) @(negedge clk);
      chk("rand_mem_q_empty", 32'(exp_mem_q.size()), 32'h0);
      chk("rand_rd_q_empty", 32'(exp_rd_q.size()), 32'h0);
      chk("rand_no_perr", 32'(perr), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
